// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the sequential calculator core.
//   op_t           3-bit operation code carried on op_sel
//   state_t        controller states of seq_calc_core
//   OP_ILLEGAL_MIN first op_sel encoding with no operation behind it
// Optional feature macro: CALC_REM_EN (REM support, see seq_calc_core).
package calc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_REM = 3'd4
  } op_t;

  localparam logic [2:0] OP_ILLEGAL_MIN = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ALU  = 3'd2,
    S_ITER = 3'd3,
    S_FIX  = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle pulse; dividend/divisor sampled on that edge
//   dividend, divisor WIDTH-bit unsigned operands
//   done              high during the final iteration cycle; quotient and
//                     remainder are valid from the following cycle
//   quotient          WIDTH-bit unsigned quotient
//   remainder         WIDTH-bit unsigned remainder (only when CALC_REM_EN)
// Handshake: start is a request pulse with no back-pressure; the caller must
// not pulse start again before done. A zero divisor is the caller's problem.
// Optional feature macro: CALC_REM_EN exports the remainder register.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
`ifdef CALC_REM_EN
  ,
  output logic [WIDTH-1:0] remainder
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic [WIDTH:0]   trial;

  // Shift the next dividend bit into the partial remainder and try to
  // subtract; a clear top bit means the subtraction did not go negative.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CW'(WIDTH);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) run_q <= 1'b0;
    end
  end

  assign done     = run_q && (cnt_q == CW'(1));
  assign quotient = quo_q;
`ifdef CALC_REM_EN
  assign remainder = rem_q;
`endif

endmodule

// File: rtl/seq_calc_core.sv
// seq_calc_core: multi-cycle signed calculator (ADD/SUB/MUL/DIV[/REM]).
// Ports:
//   clk, rst_n, clear   clock, synchronous active-low reset, soft clear
//   op_start, op_sel    request pulse and op code (calc_pkg::op_t)
//   opa, opb            WIDTH-bit signed operands
//   busy, done          busy from accept until done; done is a 1-cycle pulse
//   result              RES_W-bit signed result, res_neg / res_mag its
//                       sign and magnitude
//   div_zero, illegal   error flags, held with result
//   fsm_state           current controller state (calc_pkg::state_t)
// Handshake: a request is accepted on a posedge where the core is IDLE and
// op_start is high; operands and op_sel are captured on that edge. op_start
// at any other time (busy or DONE) is dropped, nothing is queued. done marks
// the single cycle in which a fresh result and flags first appear.
// Optional feature macro: CALC_REM_EN enables REM (op 4); without it op 4
// is reported as illegal and the divider's remainder is not exported.
module seq_calc_core
  import calc_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int RES_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             op_start,
  input  logic [2:0]       op_sel,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             res_neg,
  output logic [RES_W-1:0] res_mag,
  output logic             div_zero,
  output logic             illegal,
  output logic [2:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic             srst;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, a_mag, b_mag;
  logic             neg_q, dz_q, ill_q;
  logic [RES_W-1:0] acc_q, mcand_q, a_ext, b_ext;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             op_illegal, use_div, zero_div, div_start, div_done;
  logic [WIDTH-1:0] quotient;
  logic [RES_W-1:0] mag_src, fix_val, fix_mag;
`ifdef CALC_REM_EN
  logic [WIDTH-1:0] remainder;
`endif

  assign srst      = !rst_n || clear;
  assign fsm_state = state_q;

  assign a_mag = a_q[WIDTH-1] ? -a_q : a_q;
  assign b_mag = b_q[WIDTH-1] ? -b_q : b_q;
  assign a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};

`ifdef CALC_REM_EN
  assign op_illegal = (op_q >= OP_ILLEGAL_MIN);
`else
  assign op_illegal = (op_q >= OP_ILLEGAL_MIN) || (op_q == OP_REM);
`endif
  assign use_div   = !op_illegal && ((op_q == OP_DIV) || (op_q == OP_REM));
  assign zero_div  = use_div && (b_q == '0);
  assign div_start = (state_q == S_LOAD) && use_div && !zero_div;

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (!srst),
    .start    (div_start),
    .dividend (a_mag),
    .divisor  (b_mag),
    .done     (div_done),
    .quotient (quotient)
`ifdef CALC_REM_EN
    ,
    .remainder(remainder)
`endif
  );

  // Unsigned magnitude to present in FIX; errors force a zero result.
  always_comb begin
    mag_src = acc_q;
    if (dz_q || ill_q)          mag_src = '0;
    else if (op_q == OP_DIV)    mag_src = {{WIDTH{1'b0}}, quotient};
`ifdef CALC_REM_EN
    else if (op_q == OP_REM)    mag_src = {{WIDTH{1'b0}}, remainder};
`endif
  end

  assign fix_val = neg_q ? -mag_src : mag_src;
  assign fix_mag = fix_val[RES_W-1] ? -fix_val : fix_val;

  always_ff @(posedge clk) begin
    if (srst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (op_start) state_d = S_LOAD;
      S_LOAD: begin
        busy = 1'b1;
        if (op_illegal || zero_div)                    state_d = S_FIX;
        else if ((op_q == OP_ADD) || (op_q == OP_SUB)) state_d = S_ALU;
        else                                           state_d = S_ITER;
      end
      S_ALU: begin
        busy    = 1'b1;
        state_d = S_FIX;
      end
      S_ITER: begin
        busy = 1'b1;
        // Divider and multiplier both run WIDTH cycles from LOAD exit.
        if (use_div ? div_done : (cnt_q == CW'(1))) state_d = S_FIX;
      end
      S_FIX: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ill_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result   <= '0;
      res_neg  <= 1'b0;
      res_mag  <= '0;
      div_zero <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (op_start) begin
          op_q     <= op_sel;
          a_q      <= opa;
          b_q      <= opb;
          div_zero <= 1'b0;
          illegal  <= 1'b0;
        end
        S_LOAD: begin
          dz_q     <= zero_div;
          ill_q    <= op_illegal;
          acc_q    <= '0;
          mcand_q  <= {{WIDTH{1'b0}}, a_mag};
          mplier_q <= b_mag;
          cnt_q    <= CW'(WIDTH);
          // Remainder follows the dividend; product/quotient follow both.
          if (op_q == OP_REM)                             neg_q <= a_q[WIDTH-1];
          else if ((op_q == OP_MUL) || (op_q == OP_DIV))  neg_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          else                                            neg_q <= 1'b0;
        end
        S_ALU: acc_q <= (op_q == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
        S_ITER: begin
          cnt_q    <= cnt_q - 1'b1;
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
        end
        S_FIX: begin
          result   <= fix_val;
          res_neg  <= fix_val[RES_W-1];
          res_mag  <= fix_mag;
          div_zero <= dz_q;
          illegal  <= ill_q;
        end
        default: ;
      endcase
    end
  end

endmodule
